// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the two-requester APB command arbiter.
package apb_arb_pkg;

  localparam int NREQ   = 2;
  localparam int ARB_AW = 9;
  localparam int ARB_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [ARB_DW-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// whoever was not served last.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_valid,
  input  logic            last_grant,
  output logic            grant,
  output logic            grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    grant       = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Serialises two command requesters onto the APB bridge command port, one
// transfer at a time, with a bounded wait for the bridge to finish.
//
// state | meaning
// IDLE  | waiting for a request; grant accepted combinationally
// BUSY  | transfer held high, waiting for xfer_done or timeout
// RESP  | bridge outputs cleared, one-cycle rsp_valid to the owner
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_write,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              transfer,
  output logic              READ_WRITE,
  output logic [AW-1:0]     apb_write_paddr,
  output logic [DW-1:0]     apb_write_data,
  output logic [AW-1:0]     apb_read_paddr,
  input  logic [DW-1:0]     apb_read_data_out,
  input  logic              xfer_done,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state;
  logic          last_grant;
  logic          grant_q;
  logic [CW-1:0] cnt;
  rsp_t          rsp_q;
  cmd_t          cmd_sel;
  logic          grant;
  logic          grant_valid;

  rr_arb2 u_rr_arb2 (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    cmd_sel       = '0;
    cmd_sel.write = req_write[grant];
    cmd_sel.addr  = grant ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    cmd_sel.wdata = grant ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  end

  assign req_ready = (state == IDLE && grant_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      grant_q         <= 1'b0;
      cnt             <= '0;
      rsp_q           <= '0;
      rsp_valid       <= '0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b0;
      apb_write_paddr <= '0;
      apb_write_data  <= '0;
      apb_read_paddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= '0;
          rsp_q     <= '0;
          if (grant_valid) begin
            grant_q         <= grant;
            cnt             <= '0;
            transfer        <= 1'b1;
            READ_WRITE      <= cmd_sel.write;
            apb_write_paddr <= cmd_sel.write ? cmd_sel.addr  : '0;
            apb_write_data  <= cmd_sel.write ? cmd_sel.wdata : '0;
            apb_read_paddr  <= cmd_sel.write ? '0 : cmd_sel.addr;
            state           <= BUSY;
          end
        end
        BUSY: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (xfer_done || cnt == CNT_LAST) begin
            rsp_q.rdata     <= (xfer_done && !READ_WRITE) ? apb_read_data_out : '0;
            rsp_q.err       <= !xfer_done;
            rsp_valid       <= grant_q ? 2'b10 : 2'b01;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
            state           <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid  <= '0;
          rsp_q      <= '0;
          last_grant <= grant_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
